i2c_apb_regfile_v2: RTL and testbench
=====================================

Name: i2c_apb_regfile_v2

Overview:
- Parametrised APB3 slave register file for the I2C master core; second generation of the APB-to-core register block.
- Adds over the first generation:
  - configurable data width and reset prescaler;
  - PREADY wait states on RX reads, with a timeout;
  - PSLVERR for bad accesses;
  - single-cycle FIFO push/pop strobes;
  - sticky write-1-to-clear interrupt status with enable mask and a registered IRQ line.
- Sits between the APB interconnect and the I2C core and its TX/RX FIFOs.

Parameters:
- DATA_WIDTH, 8, width of pwdata/prdata and of every register.
- ADDR_WIDTH, 8, APB address width. Register index is paddr_i[ADDR_WIDTH-1:0]; byte addressing, one register per address.
- PRESCALER_RST, 8'h00, reset value of PRESCALER (zero-extended to DATA_WIDTH).
- RX_WAIT_MAX, 15, maximum wait-state cycles on an empty-FIFO RECEIVE read before an error response. Range 1..255.

Ports:
- pclk_i  in  1  clock; all logic on rising edge.
- preset_i  in  1  synchronous reset, active-high.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable (access phase).
- pwrite_i  in  1  1=write, 0=read.
- paddr_i  in  ADDR_WIDTH  register address.
- pwdata_i  in  DATA_WIDTH  write data.
- prdata_o  out  DATA_WIDTH  read data; valid when pready_o=1 in the access phase, 0 otherwise.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error response; valid only with pready_o=1.
- receive_i  in  DATA_WIDTH  RX FIFO head (show-ahead).
- rx_empty_i  in  1  RX FIFO empty.
- tx_full_i  in  1  TX FIFO full.
- status_i  in  DATA_WIDTH  live core status.
- irq_event_i  in  DATA_WIDTH  per-bit single-cycle event pulses from the core.
- prescaler_o / cmd_o / address_rw_o / transmit_o  out  DATA_WIDTH  register contents.
- tx_fifo_write_enable_o  out  1  TX push strobe.
- rx_fifo_read_enable_o  out  1  RX pop strobe.
- irq_o  out  1  interrupt request.

Behaviour:
- Register map:
  - 0x00 PRESCALER RW.
  - 0x01 CMD RW.
  - 0x02 TRANSMIT RW: a write also pushes to the TX FIFO.
  - 0x03 RECEIVE RO: a read pops the RX FIFO.
  - 0x04 ADDRESS_RW RW.
  - 0x05 STATUS RO = status_i.
  - 0x06 IRQ_STAT RW1C.
  - 0x07 IRQ_EN RW.
  - Any other address: read returns 0 and write is ignored; both complete with pslverr_o=1.
- Reset (preset_i=1, synchronous):
  - PRESCALER=PRESCALER_RST; all other registers 0.
  - Strobes 0; irq_o 0; wait counter 0; FSM in IDLE.
  - During reset, pready_o=1, prdata_o=0, pslverr_o=0.
  - Reset asserted mid-transfer aborts it; no push/pop is issued.
- APB FSM states: IDLE, SETUP (psel & !penable), ACCESS (psel & penable), WAIT (ACCESS on RECEIVE with rx_empty_i=1).
- Zero-wait transfers:
  - Every access except a RECEIVE read completes in its first ACCESS cycle; pready_o is combinational and 1.
  - The write updates the register on that clock edge.
- Error writes (register unchanged, pslverr_o=1, no strobe):
  - writes to STATUS or RECEIVE;
  - a TRANSMIT write while tx_full_i=1.
- TX push: a successful TRANSMIT write updates TRANSMIT at the completing edge; tx_fifo_write_enable_o=1 for exactly the next cycle, with transmit_o already holding the new data.
- RECEIVE read:
  - If rx_empty_i=0 in ACCESS: pready_o=1, prdata_o=receive_i, and rx_fifo_read_enable_o=1 for exactly the next cycle.
  - If rx_empty_i=1: pready_o=0 and the wait counter increments each cycle.
  - The first cycle with rx_empty_i=0 completes the read as above.
  - If the counter reaches RX_WAIT_MAX first: complete with prdata_o=0, pslverr_o=1, no pop.
  - The counter clears on completion.
- IRQ_STAT bit i:
  - set when irq_event_i[i]=1;
  - cleared by writing 1 to bit i;
  - a set and a clear in the same cycle leaves the bit set.
- irq_o is registered: irq_o(n+1) = |(IRQ_STAT(n) & IRQ_EN(n)).
- Strobes never overlap each other and are never asserted for longer than 1 cycle.
- Back-to-back transfers (ACCESS directly followed by SETUP) are supported with no idle cycle.

Test Plan:
- Reset with PRESCALER_RST=8'h10 → PRESCALER reads 0x10, CMD reads 0, irq_o=0. Write 0x5A to 0x00 then read → 0x5A, pslverr_o=0, zero wait states.
- Write 0xA5 to 0x02 with tx_full_i=0 → transmit_o=0xA5 and a one-cycle tx_fifo_write_enable_o pulse. Repeat with tx_full_i=1 → pslverr_o=1, no pulse, transmit_o stays 0xA5.
- Read 0x03 with rx_empty_i=1 for 3 cycles, then receive_i=0x3C with empty deasserted → 3 wait states, prdata_o=0x3C, one rx_fifo_read_enable_o pulse.
- Read 0x03 with rx_empty_i held at 1 and RX_WAIT_MAX=15 → completes after 15 wait states with pslverr_o=1, prdata_o=0, no pop.
- Write IRQ_EN=0x01, pulse irq_event_i=0x01 → irq_o=1 one cycle after IRQ_STAT sets. Write 0x01 to 0x06 in the same cycle as a new event pulse → bit stays set. A later write of 0x01 with no event → clears, irq_o drops.
- Write to 0x05 and read 0x09 → both pslverr_o=1; STATUS is unaffected; the read returns 0.

Source files
------------

// File: rtl/i2c_apb_regfile_v2_if.sv
// APB3 bus bundle between the interconnect and the I2C register file.
interface i2c_apb_regfile_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/i2c_apb_regfile_v2.sv
// APB3 register file for the I2C master core: config, FIFO strobes,
// RX wait states with timeout, error responses and masked sticky IRQs.
module i2c_apb_regfile_v2 #(
    parameter int         DATA_WIDTH    = 8,
    parameter int         ADDR_WIDTH    = 8,
    parameter logic [7:0] PRESCALER_RST = 8'h00,
    parameter int         RX_WAIT_MAX   = 15
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    i2c_apb_regfile_v2_if.slave   apb,
    input  logic [DATA_WIDTH-1:0] receive_i,
    input  logic                  rx_empty_i,
    input  logic                  tx_full_i,
    input  logic [DATA_WIDTH-1:0] status_i,
    input  logic [DATA_WIDTH-1:0] irq_event_i,
    output logic [DATA_WIDTH-1:0] prescaler_o,
    output logic [DATA_WIDTH-1:0] cmd_o,
    output logic [DATA_WIDTH-1:0] address_rw_o,
    output logic [DATA_WIDTH-1:0] transmit_o,
    output logic                  tx_fifo_write_enable_o,
    output logic                  rx_fifo_read_enable_o,
    output logic                  irq_o
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT} state_t;

    state_t                state, state_nxt;
    logic [7:0]            wait_cnt, wait_cnt_nxt;
    logic [DATA_WIDTH-1:0] irq_stat, irq_en, irq_clr, rd_val;
    logic sel_pre, sel_cmd, sel_tx, sel_rx;
    logic sel_adr, sel_status, sel_istat, sel_ien;
    logic access, rx_rd, timeout, stall, done;
    logic bad_addr, wr_err, rd_err, err, wr_ok, pop;

    always_comb begin
        sel_pre    = apb.paddr == ADDR_WIDTH'(0);
        sel_cmd    = apb.paddr == ADDR_WIDTH'(1);
        sel_tx     = apb.paddr == ADDR_WIDTH'(2);
        sel_rx     = apb.paddr == ADDR_WIDTH'(3);
        sel_adr    = apb.paddr == ADDR_WIDTH'(4);
        sel_status = apb.paddr == ADDR_WIDTH'(5);
        sel_istat  = apb.paddr == ADDR_WIDTH'(6);
        sel_ien    = apb.paddr == ADDR_WIDTH'(7);
        bad_addr   = !(sel_pre || sel_cmd || sel_tx || sel_rx ||
                       sel_adr || sel_status || sel_istat || sel_ien);
    end

    // An access phase only counts when it follows SETUP (or continues a wait),
    // so a transfer interrupted by reset is never resumed.
    always_comb begin
        access  = apb.psel && apb.penable &&
                  (state == SETUP || state == WAIT);
        rx_rd   = access && !apb.pwrite && sel_rx;
        timeout = wait_cnt == 8'(RX_WAIT_MAX);
        stall   = rx_rd && rx_empty_i && !timeout;
        done    = access && !stall && !preset_i;
        wr_err  = bad_addr || sel_rx || sel_status || (sel_tx && tx_full_i);
        rd_err  = bad_addr || (sel_rx && rx_empty_i);
        err     = apb.pwrite ? wr_err : rd_err;
        wr_ok   = done && apb.pwrite && !wr_err;
        pop     = done && rx_rd && !rx_empty_i;
        irq_clr = (wr_ok && sel_istat) ? apb.pwdata : '0;
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            sel_pre:    rd_val = prescaler_o;
            sel_cmd:    rd_val = cmd_o;
            sel_tx:     rd_val = transmit_o;
            sel_rx:     rd_val = receive_i;
            sel_adr:    rd_val = address_rw_o;
            sel_status: rd_val = status_i;
            sel_istat:  rd_val = irq_stat;
            sel_ien:    rd_val = irq_en;
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        apb.pready  = preset_i || !stall;
        apb.prdata  = (done && !apb.pwrite && !rd_err) ? rd_val : '0;
        apb.pslverr = done && err;
    end

    always_comb begin
        state_nxt    = IDLE;
        wait_cnt_nxt = '0;
        if (apb.psel && !apb.penable) begin
            state_nxt = SETUP;
        end else if (stall) begin
            state_nxt    = WAIT;
            wait_cnt_nxt = wait_cnt + 8'd1;
        end else if (access) begin
            state_nxt = ACCESS;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state                  <= IDLE;
            wait_cnt               <= '0;
            prescaler_o            <= DATA_WIDTH'(PRESCALER_RST);
            cmd_o                  <= '0;
            transmit_o             <= '0;
            address_rw_o           <= '0;
            irq_stat               <= '0;
            irq_en                 <= '0;
            tx_fifo_write_enable_o <= 1'b0;
            rx_fifo_read_enable_o  <= 1'b0;
            irq_o                  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (wr_ok && sel_pre) prescaler_o  <= apb.pwdata;
            if (wr_ok && sel_cmd) cmd_o        <= apb.pwdata;
            if (wr_ok && sel_tx)  transmit_o   <= apb.pwdata;
            if (wr_ok && sel_adr) address_rw_o <= apb.pwdata;
            if (wr_ok && sel_ien) irq_en       <= apb.pwdata;
            // New events win over a simultaneous write-1-to-clear.
            irq_stat               <= (irq_stat & ~irq_clr) | irq_event_i;
            tx_fifo_write_enable_o <= wr_ok && sel_tx;
            rx_fifo_read_enable_o  <= pop;
            irq_o                  <= |(irq_stat & irq_en);
        end
    end
endmodule

// File: tb/tb_i2c_apb_regfile_v2.sv
// Randomised and directed bench for i2c_apb_regfile_v2 against an
// address-map reference model.
module tb_i2c_apb_regfile_v2;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int WMAX = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_apb_regfile_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [DW-1:0] receive, status, irq_event;
    logic [DW-1:0] prescaler, cmd, address_rw, transmit;
    logic          rx_empty, tx_full, tx_we, rx_re, irq;

    i2c_apb_regfile_v2 #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .PRESCALER_RST(8'h10),
        .RX_WAIT_MAX  (WMAX)
    ) dut (
        .pclk_i                (clk),
        .preset_i              (rst),
        .apb                   (bus),
        .receive_i             (receive),
        .rx_empty_i            (rx_empty),
        .tx_full_i             (tx_full),
        .status_i              (status),
        .irq_event_i           (irq_event),
        .prescaler_o           (prescaler),
        .cmd_o                 (cmd),
        .address_rw_o          (address_rw),
        .transmit_o            (transmit),
        .tx_fifo_write_enable_o(tx_we),
        .rx_fifo_read_enable_o (rx_re),
        .irq_o                 (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state: register contents by address, expected pulse totals.
    logic [DW-1:0] m_reg [8];
    int exp_tx = 0;
    int exp_rx = 0;

    int   tx_cnt = 0, rx_cnt = 0, overlap = 0, tx_long = 0, rx_long = 0;
    logic tx_prev = 1'b0, rx_prev = 1'b0;
    always @(negedge clk) begin
        if (tx_we) tx_cnt++;
        if (rx_re) rx_cnt++;
        if (tx_we && rx_re) overlap++;
        if (tx_we && tx_prev) tx_long++;
        if (rx_re && rx_prev) rx_long++;
        tx_prev = tx_we;
        rx_prev = rx_re;
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_reg[0] = 8'h10;
    endtask

    task automatic xfer(input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int ec,
                        input logic [DW-1:0] ev,
                        output logic [DW-1:0] rdata, output logic err,
                        output int waits);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = a;
        bus.pwdata  = d;
        rx_empty    = (ec > 0);
        waits = 0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        irq_event   = ev;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.pready) begin
                rdata = bus.prdata;
                err   = bus.pslverr;
                break;
            end
            waits++;
            @(posedge clk); #1;
            if (waits >= ec) rx_empty = 1'b0;
        end
        @(posedge clk); #1;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        irq_event   = '0;
        rx_empty    = 1'b1;
    endtask

    // One transfer plus its expected outcome from the register map rules.
    task automatic txn(input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int ec,
                       input logic [DW-1:0] ev, input string tag);
        logic [DW-1:0] e_rd, rd;
        logic          e_err, er;
        int            e_wait, w;
        e_rd = '0;
        e_err = 1'b0;
        e_wait = 0;
        if (wr) begin
            e_err = (a > 7) || a == 3 || a == 5 || (a == 2 && tx_full);
            if (!e_err) begin
                if (a == 6) m_reg[6] = m_reg[6] & ~d;
                else m_reg[a[2:0]] = d;
                if (a == 2) exp_tx++;
            end
        end else if (a == 3) begin
            if (ec > WMAX) begin
                e_wait = WMAX;
                e_err  = 1'b1;
            end else begin
                e_wait = ec;
                e_rd   = receive;
                exp_rx++;
            end
        end else if (a == 5) begin
            e_rd = status;
        end else if (a > 7) begin
            e_err = 1'b1;
        end else begin
            e_rd = m_reg[a[2:0]];
        end
        m_reg[6] = m_reg[6] | ev;
        xfer(wr, a, d, ec, ev, rd, er, w);
        check({tag, " waits"}, w, e_wait);
        check({tag, " pslverr"}, er, e_err);
        if (!wr) check({tag, " prdata"}, rd, e_rd);
    endtask

    task automatic settle(input logic [DW-1:0] ev, input string tag);
        irq_event = ev;
        @(posedge clk); #1;
        irq_event = '0;
        m_reg[6] = m_reg[6] | ev;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check({tag, " prescaler"}, prescaler, m_reg[0]);
        check({tag, " cmd"}, cmd, m_reg[1]);
        check({tag, " transmit"}, transmit, m_reg[2]);
        check({tag, " address_rw"}, address_rw, m_reg[4]);
        check({tag, " irq"}, irq, |(m_reg[6] & m_reg[7]));
        check({tag, " tx pushes"}, tx_cnt, exp_tx);
        check({tag, " rx pops"}, rx_cnt, exp_rx);
    endtask

    initial begin
        logic          wr;
        logic [AW-1:0] a;
        int            ec;
        rst = 1'b1;
        bus.psel = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite = 1'b0;
        bus.paddr = 8'h03;
        bus.pwdata = '0;
        rx_empty = 1'b1;
        tx_full = 1'b0;
        status = '0;
        receive = '0;
        irq_event = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check("reset pready", bus.pready, 1'b1);
            check("reset prdata", bus.prdata, 8'h00);
            check("reset pslverr", bus.pslverr, 1'b0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        check("reset prescaler_o", prescaler, 8'h10);
        check("reset irq", irq, 1'b0);
        txn(1'b0, 8'h00, 8'h00, 0, 8'h00, "rst pre rd");
        txn(1'b0, 8'h01, 8'h00, 0, 8'h00, "rst cmd rd");
        txn(1'b1, 8'h00, 8'h5A, 0, 8'h00, "pre wr");
        txn(1'b0, 8'h00, 8'h00, 0, 8'h00, "pre rd");
        settle(8'h00, "basic");

        txn(1'b1, 8'h02, 8'hA5, 0, 8'h00, "tx wr");
        settle(8'h00, "tx push");
        tx_full = 1'b1;
        txn(1'b1, 8'h02, 8'h11, 0, 8'h00, "tx full wr");
        settle(8'h00, "tx full");
        tx_full = 1'b0;

        receive = 8'h3C;
        txn(1'b0, 8'h03, 8'h00, 3, 8'h00, "rx wait3");
        settle(8'h00, "rx pop");
        txn(1'b0, 8'h03, 8'h00, 99, 8'h00, "rx timeout");
        settle(8'h00, "rx timeout");

        txn(1'b1, 8'h07, 8'h01, 0, 8'h00, "irq en wr");
        settle(8'h00, "irq en");
        irq_event = 8'h01;
        @(posedge clk); #1;
        irq_event = '0;
        m_reg[6] = m_reg[6] | 8'h01;
        check("irq lag", irq, 1'b0);
        @(posedge clk); #1;
        check("irq rise", irq, 1'b1);
        txn(1'b1, 8'h06, 8'h01, 0, 8'h01, "w1c+event");
        txn(1'b0, 8'h06, 8'h00, 0, 8'h00, "stat after race");
        settle(8'h00, "irq held");
        txn(1'b1, 8'h06, 8'h01, 0, 8'h00, "w1c");
        settle(8'h00, "irq clear");

        status = 8'h96;
        txn(1'b1, 8'h05, 8'hFF, 0, 8'h00, "status wr");
        txn(1'b0, 8'h05, 8'h00, 0, 8'h00, "status rd");
        txn(1'b0, 8'h09, 8'h00, 0, 8'h00, "bad rd");
        settle(8'h00, "errors");

        bus.psel = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite = 1'b1;
        bus.paddr = 8'h02;
        bus.pwdata = 8'h77;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.psel = 1'b0;
        bus.penable = 1'b0;
        model_reset();
        settle(8'h00, "abort");

        txn(1'b1, 8'h01, 8'h33, 0, 8'h00, "b2b cmd");
        txn(1'b1, 8'h04, 8'h44, 0, 8'h00, "b2b adr");
        txn(1'b0, 8'h01, 8'h00, 0, 8'h00, "b2b rd");
        settle(8'h00, "b2b");

        for (int n = 0; n < 150; n++) begin
            a = AW'($urandom_range(0, 9));
            wr = 1'($urandom_range(0, 1));
            tx_full = ($urandom_range(0, 3) == 0);
            status = DW'($urandom);
            receive = DW'($urandom);
            ec = 0;
            if (a == 3)
                ec = ($urandom_range(0, 4) == 0) ? 20 : $urandom_range(0, 12);
            txn(wr, a, DW'($urandom), ec, 8'h00, "rand");
            if ($urandom_range(0, 1) == 0)
                settle(($urandom_range(0, 3) == 0) ? DW'($urandom) : 8'h00,
                       "rand");
        end
        settle(8'h00, "final");
        check("strobe overlap", overlap, 0);
        check("tx pulse len", tx_long, 0);
        check("rx pulse len", rx_long, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
